rf_seq: RTL and testbench



---
 rtl/rf_seq_if.sv | 29 ++
 rtl/rf_seq.sv | 158 +++++++++++++++
 tb/tb_rf_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rf_seq_if.sv
// Command and register-file control bundle for rf_seq.
// The sequencer takes the slave side; whoever issues commands and owns the register file takes the master side.
interface rf_seq_if;
   logic       CmdValid;
   logic       CmdReady;
   logic [2:0] CmdOp;
   logic [2:0] CmdDst;
   logic [2:0] CmdSrc;
   logic [7:0] CmdImm;
   logic [7:0] RFData1;
   logic [7:0] RFInput;
   logic [1:0] FunSel;
   logic [3:0] RSel;
   logic [3:0] TSel;
   logic [2:0] O1Sel;
   logic [2:0] O2Sel;
   logic       Done;
   logic       Err;

   modport master (
      output CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, RFData1,
      input  CmdReady, RFInput, FunSel, RSel, TSel, O1Sel, O2Sel, Done, Err
   );

   modport slave (
      input  CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, RFData1,
      output CmdReady, RFInput, FunSel, RSel, TSel, O1Sel, O2Sel, Done, Err
   );
endinterface

// File: rtl/rf_seq.sv
// Register-file command sequencer: turns one command into read/write strobe cycles.
// Define RF_SEQ_REPEAT_EN to enable INCN/DECN repeat ops; otherwise they complete with Err.
module rf_seq (
   input logic   Clock,
   input logic   Reset,
   rf_seq_if.slave bus
);
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_CLR  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_MOV  = 3'b101;
   localparam logic [2:0] OP_INCN = 3'b110;
   localparam logic [2:0] OP_DECN = 3'b111;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_GAP, S_DONE} state_t;

   state_t     r_state;
   logic [3:0] r_rsel;
   logic [3:0] r_tsel;
   logic [1:0] r_fun_sel;
   logic [7:0] r_rf_input;
   logic [2:0] r_o1_sel;
   logic [2:0] r_o2_sel;
   logic       r_done;
   logic       r_err;
`ifdef RF_SEQ_REPEAT_EN
   logic [3:0] r_count;
`endif

   function automatic logic [1:0] f_fun_sel(input logic [2:0] op);
      case (op)
         OP_NOP, OP_CLR:   return 2'b00;
         OP_LOAD, OP_MOV:  return 2'b01;
         OP_INC, OP_INCN:  return 2'b11;
         OP_DEC, OP_DECN:  return 2'b10;
         default:          return 2'b00;
      endcase
   endfunction

   // Index 0-3 addresses T1-T4, 4-7 addresses R1-R4; lowest index is the MSB strobe.
   function automatic logic [3:0] f_tstrb(input logic [2:0] dst);
      return dst[2] ? 4'b0000 : (4'b1000 >> dst[1:0]);
   endfunction

   function automatic logic [3:0] f_rstrb(input logic [2:0] dst);
      return dst[2] ? (4'b1000 >> dst[1:0]) : 4'b0000;
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_rsel     <= 4'b0000;
         r_tsel     <= 4'b0000;
         r_fun_sel  <= 2'b00;
         r_rf_input <= 8'h00;
         r_o1_sel   <= 3'b000;
         r_o2_sel   <= 3'b000;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef RF_SEQ_REPEAT_EN
         r_count    <= 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.CmdValid) begin
                  r_o2_sel   <= bus.CmdDst;
                  r_fun_sel  <= f_fun_sel(bus.CmdOp);
                  r_rf_input <= (bus.CmdOp == OP_LOAD) ? bus.CmdImm : 8'h00;
                  case (bus.CmdOp)
                     OP_NOP: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                     OP_MOV: begin
                        r_state  <= S_READ;
                        r_o1_sel <= bus.CmdSrc;
                     end
                     OP_INCN, OP_DECN: begin
`ifdef RF_SEQ_REPEAT_EN
                        if (bus.CmdImm[3:0] == 4'd0) begin
                           r_state <= S_DONE;
                           r_done  <= 1'b1;
                        end else begin
                           r_state <= S_WRITE;
                           r_rsel  <= f_rstrb(bus.CmdDst);
                           r_tsel  <= f_tstrb(bus.CmdDst);
                           r_count <= bus.CmdImm[3:0];
                        end
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
`endif
                     end
                     default: begin
                        r_state <= S_WRITE;
                        r_rsel  <= f_rstrb(bus.CmdDst);
                        r_tsel  <= f_tstrb(bus.CmdDst);
`ifdef RF_SEQ_REPEAT_EN
                        r_count <= 4'd1;
`endif
                     end
                  endcase
               end
            end
            S_READ: begin
               r_state    <= S_WRITE;
               r_o1_sel   <= 3'b000;
               r_rf_input <= bus.RFData1;
               r_rsel     <= f_rstrb(r_o2_sel);
               r_tsel     <= f_tstrb(r_o2_sel);
            end
            S_WRITE: begin
               r_rsel <= 4'b0000;
               r_tsel <= 4'b0000;
`ifdef RF_SEQ_REPEAT_EN
               if (r_count > 4'd1) begin
                  r_state <= S_GAP;
                  r_count <= r_count - 4'd1;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
`else
               r_state <= S_DONE;
               r_done  <= 1'b1;
`endif
            end
            S_GAP: begin
               r_state <= S_WRITE;
               r_rsel  <= f_rstrb(r_o2_sel);
               r_tsel  <= f_tstrb(r_o2_sel);
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_done   <= 1'b0;
               r_err    <= 1'b0;
               r_o2_sel <= 3'b000;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Ready is forced low while Reset is held so a command offered then is never seen as accepted.
   assign bus.CmdReady = (r_state == S_IDLE) && !Reset;
   assign bus.RSel     = r_rsel;
   assign bus.TSel     = r_tsel;
   assign bus.FunSel   = r_fun_sel;
   assign bus.RFInput  = r_rf_input;
   assign bus.O1Sel    = r_o1_sel;
   assign bus.O2Sel    = r_o2_sel;
   assign bus.Done     = r_done;
   assign bus.Err      = r_err;
endmodule

// File: tb/tb_rf_seq.sv
// Self-checking bench for rf_seq: a spec model queues expected per-cycle outputs per command,
// and each cycle after acceptance pops one entry and compares it with the sampled outputs.
module tb_rf_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_seq_if bus();

   rf_seq dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   // Packed layout: {pad5, RSel4, TSel4, FunSel2, RFInput8, O1Sel3, O2Sel3, Done, Err, CmdReady}
   localparam logic [31:0] M_BASE = 32'h07F8_003F;
   localparam logic [31:0] M_FS   = 32'h0006_0000;
   localparam logic [31:0] M_RFI  = 32'h0001_FE00;
   localparam logic [31:0] M_O1   = 32'h0000_01C0;

   typedef struct {
      logic [31:0] vec;
      logic [31:0] mask;
      bit          is_read;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s got %h want %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] rs, input logic [3:0] ts,
                                      input logic [1:0] fs, input logic [7:0] rfi,
                                      input logic [2:0] o1, input logic [2:0] o2,
                                      input logic d, input logic e, input logic r);
      return {5'b0, rs, ts, fs, rfi, o1, o2, d, e, r};
   endfunction

   function automatic logic [31:0] obs_vec();
      return {5'b0, bus.RSel, bus.TSel, bus.FunSel, bus.RFInput, bus.O1Sel, bus.O2Sel,
              bus.Done, bus.Err, bus.CmdReady};
   endfunction

   task automatic push(input logic [31:0] v, input logic [31:0] m, input bit rd, input string tag);
      exp_t e;
      e.vec = v; e.mask = m; e.is_read = rd; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [7:0] imm, input bit hold_valid);
      logic [3:0] rs, ts;
      logic [1:0] fs;
      logic       err;
      exp_t       e;
      int         cyc;
      ts  = dst[2] ? 4'b0000 : (4'b1000 >> dst[1:0]);
      rs  = dst[2] ? (4'b1000 >> dst[1:0]) : 4'b0000;
      err = 1'b0;
      cyc = 0;
      case (op)
         3'b010, 3'b101: fs = 2'b01;
         3'b011, 3'b110: fs = 2'b11;
         3'b100, 3'b111: fs = 2'b10;
         default:        fs = 2'b00;
      endcase

      @(negedge clk);
      chk("idle_rdy", {31'b0, bus.CmdReady}, 32'd1);
      bus.CmdValid = 1'b1;
      bus.CmdOp    = op;
      bus.CmdDst   = dst;
      bus.CmdSrc   = src;
      bus.CmdImm   = imm;
      bus.RFData1  = 8'hA5;

      case (op)
         3'b000: ;
         3'b101: begin
            push(mk(4'b0, 4'b0, 2'b0, 8'h00, src, dst, 1'b0, 1'b0, 1'b0), M_BASE | M_O1, 1'b1, "mov_read");
            push(mk(rs, ts, 2'b01, 8'h3C, 3'b0, dst, 1'b0, 1'b0, 1'b0), M_BASE | M_FS | M_RFI, 1'b0, "mov_write");
         end
         3'b110, 3'b111: begin
`ifdef RF_SEQ_REPEAT_EN
            for (int i = 0; i < int'(imm[3:0]); i++) begin
               push(mk(rs, ts, fs, 8'h00, 3'b0, dst, 1'b0, 1'b0, 1'b0), M_BASE | M_FS | M_RFI, 1'b0, "rep_write");
               if (i < int'(imm[3:0]) - 1)
                  push(mk(4'b0, 4'b0, fs, 8'h00, 3'b0, dst, 1'b0, 1'b0, 1'b0), M_BASE | M_FS, 1'b0, "rep_gap");
            end
`else
            err = 1'b1;
`endif
         end
         default: begin
            push(mk(rs, ts, fs, (op == 3'b010) ? imm : 8'h00, 3'b0, dst, 1'b0, 1'b0, 1'b0),
                 M_BASE | M_FS | M_RFI, 1'b0, "write");
         end
      endcase
      push(mk(4'b0, 4'b0, 2'b0, 8'h00, 3'b0, dst, 1'b1, err, 1'b0), M_BASE, 1'b0, "done");
      push(mk(4'b0, 4'b0, 2'b0, 8'h00, 3'b0, 3'b0, 1'b0, 1'b0, 1'b1), M_BASE, 1'b0, "back_idle");

      @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         // Busy-time commands are a distinct LOAD so a wrongful accept shows up in later cycles.
         bus.CmdValid = hold_valid && (exp_q.size() > 0);
         bus.CmdOp    = 3'b010;
         bus.CmdDst   = 3'd5;
         bus.CmdImm   = 8'hEE;
         bus.RFData1  = e.is_read ? 8'h3C : 8'hA5;
         chk(e.tag, obs_vec() & e.mask, e.vec & e.mask);
         cyc++;
         @(posedge clk);
      end
      bus.CmdValid = 1'b0;
      $display("CMD op=%0d dst=%0d src=%0d imm=%02h hold=%0d cycles=%0d", op, dst, src, imm, hold_valid, cyc);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_in"}, obs_vec(), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_out"}, obs_vec() & M_BASE, mk(4'b0, 4'b0, 2'b0, 8'h00, 3'b0, 3'b0, 1'b0, 1'b0, 1'b1) & M_BASE);
      $display("RESET %s", tag);
   endtask

   task automatic abort_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] imm,
                            input int adv, input string tag);
      @(negedge clk);
      bus.CmdValid = 1'b1;
      bus.CmdOp    = op;
      bus.CmdDst   = dst;
      bus.CmdSrc   = 3'd2;
      bus.CmdImm   = imm;
      @(posedge clk);
      bus.CmdValid = 1'b0;
      repeat (adv) @(posedge clk);
      do_reset(tag);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_quiet"}, {23'b0, bus.RSel, bus.TSel, bus.Done}, 32'd0);
      end
   endtask

   initial begin
      bus.CmdValid = 1'b0;
      bus.CmdOp    = 3'b000;
      bus.CmdDst   = 3'b000;
      bus.CmdSrc   = 3'b000;
      bus.CmdImm   = 8'h00;
      bus.RFData1  = 8'hA5;

      do_reset("rst0");
      run_cmd(3'b010, 3'd4, 3'd0, 8'h5A, 1'b0);
      run_cmd(3'b101, 3'd0, 3'd7, 8'h00, 1'b0);
      run_cmd(3'b101, 3'd5, 3'd5, 8'h00, 1'b1);
      run_cmd(3'b001, 3'd3, 3'd0, 8'hFF, 1'b1);
      run_cmd(3'b011, 3'd1, 3'd0, 8'h11, 1'b0);
      run_cmd(3'b100, 3'd7, 3'd0, 8'h22, 1'b1);
      run_cmd(3'b000, 3'd2, 3'd0, 8'h00, 1'b0);
      run_cmd(3'b010, 3'd2, 3'd0, 8'hC3, 1'b0);
      run_cmd(3'b110, 3'd6, 3'd0, 8'h03, 1'b0);
      run_cmd(3'b110, 3'd6, 3'd0, 8'h00, 1'b0);
      run_cmd(3'b111, 3'd1, 3'd0, 8'h02, 1'b1);
      run_cmd(3'b111, 3'd0, 3'd0, 8'h05, 1'b0);
`ifdef RF_SEQ_REPEAT_EN
      abort_cmd(3'b110, 3'd6, 8'h04, 1, "abort_gap");
`endif
      abort_cmd(3'b101, 3'd4, 8'h00, 0, "abort_read");
      abort_cmd(3'b010, 3'd1, 8'h77, 0, "abort_write");
      run_cmd(3'b010, 3'd5, 3'd0, 8'h99, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
